// File: rtl/cache_controller_wt.sv
// -----------------------------------------------------------------------------
// cache_controller_wt
//  Control FSM for a direct-mapped, write-through, no-write-allocate data cache.
//  It keeps the tag/valid store, detects hits on the CPU address, sequences block
//  refills from memory and word writes to memory, and stalls the CPU until each
//  memory transaction completes. No data path passes through this block.
//
// Ports
//  clk           in   clock, rising edge
//  reset         in   asynchronous, active-low
//  cpu_read      in   load request, held until accepted
//  cpu_write     in   store request, held until accepted (wins over cpu_read)
//  cpu_addr      in   word address {tag,index,offset}, stable while stalled
//  cpu_stall     out  request not yet complete
//  cache_index   out  data-array block index
//  cache_offset  out  data-array word offset
//  cache_update  out  data array writes a full block from the memory bus
//  cache_refill  out  data array writes one word (write hit)
//  mem_read      out  block read request to memory
//  mem_write     out  word write request to memory
//  mem_addr      out  memory address
//  mem_ready     in   memory done, one-cycle pulse
// -----------------------------------------------------------------------------
module cache_controller_wt #(
    parameter int ADDR_WIDTH      = 10,
    parameter int SIZE_BYTE       = 512,
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int WIDTH           = 32,
    localparam int DEPTH = SIZE_BYTE / BLOCK_SIZE_BYTE,
    localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE * 8 / WIDTH),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_stall,
    output logic [IDX_W-1:0]      cache_index,
    output logic [OFF_W-1:0]      cache_offset,
    output logic                  cache_update,
    output logic                  cache_refill,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        R_MISS = 2'd1,
        FILL   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    // Set only for a write that hit; cleared after the first WRITE cycle so the
    // word is written into the array exactly once however long memory takes.
    logic                  wr_hit_reg, wr_hit_next;

    logic                  valid_reg [DEPTH];
    logic [TAG_W-1:0]      tag_reg   [DEPTH];

    // Field split of the live CPU address and of the latched address
    logic [TAG_W-1:0] cpu_tag, lat_tag;
    logic [IDX_W-1:0] cpu_idx, lat_idx;
    logic [OFF_W-1:0] cpu_off, lat_off;
    logic             hit;

    assign cpu_tag = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
    assign cpu_off = cpu_addr[OFF_W-1:0];
    assign lat_tag = addr_reg[ADDR_WIDTH-1 -: TAG_W];
    assign lat_idx = addr_reg[OFF_W +: IDX_W];
    assign lat_off = addr_reg[OFF_W-1:0];

    assign hit = valid_reg[cpu_idx] && (tag_reg[cpu_idx] == cpu_tag);

    // Tag/valid store: one register pair per block, written only in FILL.
    // Write misses never touch it (no allocate).
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= '0;
                end else if (state_reg == FILL && lat_idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    tag_reg[gi]   <= lat_tag;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wr_hit_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            wr_hit_reg <= wr_hit_next;
        end
    end

    logic                  stall_c, update_c, refill_c, mrd_c, mwr_c;
    logic [ADDR_WIDTH-1:0] maddr_c;
    logic [IDX_W-1:0]      index_c;
    logic [OFF_W-1:0]      offset_c;

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        wr_hit_next = wr_hit_reg;
        stall_c     = 1'b0;
        update_c    = 1'b0;
        refill_c    = 1'b0;
        mrd_c       = 1'b0;
        mwr_c       = 1'b0;
        maddr_c     = '0;
        index_c     = lat_idx;
        offset_c    = lat_off;

        case (state_reg)
            IDLE: begin
                // Array is addressed straight from the CPU so a read hit
                // completes with zero stall cycles.
                index_c  = cpu_idx;
                offset_c = cpu_off;
                if (cpu_write) begin
                    stall_c     = 1'b1;
                    addr_next   = cpu_addr;
                    wr_hit_next = hit;
                    state_next  = WRITE;
                end else if (cpu_read && !hit) begin
                    stall_c    = 1'b1;
                    addr_next  = cpu_addr;
                    state_next = R_MISS;
                end
            end
            R_MISS: begin
                mrd_c   = 1'b1;
                maddr_c = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                stall_c = 1'b1;
                if (mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                // Block lands in the array; the held read then hits in IDLE.
                update_c   = 1'b1;
                stall_c    = 1'b1;
                state_next = IDLE;
            end
            WRITE: begin
                mwr_c       = 1'b1;
                maddr_c     = addr_reg;
                refill_c    = wr_hit_reg;
                wr_hit_next = 1'b0;
                stall_c     = !mem_ready;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // While reset is asserted every output is forced low, so an in-flight
    // memory request is withdrawn at once rather than at the next edge.
    assign cpu_stall    = reset & stall_c;
    assign cache_update = reset & update_c;
    assign cache_refill = reset & refill_c;
    assign mem_read     = reset & mrd_c;
    assign mem_write    = reset & mwr_c;
    assign mem_addr     = reset ? maddr_c  : '0;
    assign cache_index  = reset ? index_c  : '0;
    assign cache_offset = reset ? offset_c : '0;

endmodule

// File: tb/tb_cache_controller_wt.sv
// -----------------------------------------------------------------------------
// tb_cache_controller_wt
//  Directed bench for cache_controller_wt. Each step queues the outputs expected
//  for that cycle, then pops and compares them against the DUT half a clock later.
// -----------------------------------------------------------------------------
module tb_cache_controller_wt;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_read;
    logic       cpu_write;
    logic [9:0] cpu_addr;
    logic       cpu_stall;
    logic [4:0] cache_index;
    logic [1:0] cache_offset;
    logic       cache_update;
    logic       cache_refill;
    logic       mem_read;
    logic       mem_write;
    logic [9:0] mem_addr;
    logic       mem_ready;

    always #5 clk = ~clk;

    cache_controller_wt dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_stall    (cpu_stall),
        .cache_index  (cache_index),
        .cache_offset (cache_offset),
        .cache_update (cache_update),
        .cache_refill (cache_refill),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready)
    );

    typedef struct {
        logic       stall;
        logic [4:0] idx;
        logic [1:0] off;
        logic       upd;
        logic       rfl;
        logic       mrd;
        logic       mwr;
        logic [9:0] maddr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic exp_t mk(input logic s, input logic [4:0] i, input logic [1:0] o,
                                input logic u, input logic r, input logic mr,
                                input logic mw, input logic [9:0] ma);
        exp_t e;
        e.stall = s; e.idx = i; e.off = o; e.upd = u;
        e.rfl = r; e.mrd = mr; e.mwr = mw; e.maddr = ma;
        return e;
    endfunction

    task automatic cmp(input string tag, input string fld,
                       input logic [9:0] obs, input logic [9:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    // Compare current DUT outputs with the oldest queued expectation.
    task automatic check_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s.queue observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        cmp(tag, "stall",  10'(cpu_stall),    10'(e.stall));
        cmp(tag, "index",  10'(cache_index),  10'(e.idx));
        cmp(tag, "offset", 10'(cache_offset), 10'(e.off));
        cmp(tag, "update", 10'(cache_update), 10'(e.upd));
        cmp(tag, "refill", 10'(cache_refill), 10'(e.rfl));
        cmp(tag, "mrd",    10'(mem_read),     10'(e.mrd));
        cmp(tag, "mwr",    10'(mem_write),    10'(e.mwr));
        cmp(tag, "maddr",  mem_addr,          e.maddr);
        $display("[TB] %-12s rd=%b wr=%b addr=%h rdy=%b -> stall=%b idx=%0d off=%0d upd=%b rfl=%b mrd=%b mwr=%b maddr=%h",
                 tag, cpu_read, cpu_write, cpu_addr, mem_ready, cpu_stall, cache_index,
                 cache_offset, cache_update, cache_refill, mem_read, mem_write, mem_addr);
    endtask

    // One clock cycle: queue expectation, compare at the falling edge, then move
    // to just after the next rising edge. With drop set, the CPU request is
    // withdrawn before the edge (combinational probe only).
    task automatic step(input string tag, input exp_t e, input bit drop = 1'b0);
        exp_q.push_back(e);
        @(negedge clk);
        check_now(tag);
        if (drop) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = 10'h000;
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        step("reset", mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        reset = 1'b1;

        // 1: cold read miss on 0x004, memory answers on the third R_MISS cycle
        cpu_read = 1'b1; cpu_addr = 10'h004;
        step("t1_idle", mk(1, 1, 0, 0, 0, 0, 0, 10'h000));
        step("t1_rm1",  mk(1, 1, 0, 0, 0, 1, 0, 10'h004));
        step("t1_rm2",  mk(1, 1, 0, 0, 0, 1, 0, 10'h004));
        mem_ready = 1'b1;
        step("t1_rm3",  mk(1, 1, 0, 0, 0, 1, 0, 10'h004));
        mem_ready = 1'b0;
        step("t1_fill", mk(1, 1, 0, 1, 0, 0, 0, 10'h000));
        step("t1_hit",  mk(0, 1, 0, 0, 0, 0, 0, 10'h000));
        idle_inputs();

        // 2: read hit in the same block
        cpu_read = 1'b1; cpu_addr = 10'h006;
        step("t2_hit",  mk(0, 1, 2, 0, 0, 0, 0, 10'h000));
        idle_inputs();

        // 3: write hit 0x005, memory latency 3
        cpu_write = 1'b1; cpu_addr = 10'h005;
        step("t3_idle", mk(1, 1, 1, 0, 0, 0, 0, 10'h000));
        step("t3_w1",   mk(1, 1, 1, 0, 1, 0, 1, 10'h005));
        step("t3_w2",   mk(1, 1, 1, 0, 0, 0, 1, 10'h005));
        mem_ready = 1'b1;
        step("t3_w3",   mk(0, 1, 1, 0, 0, 0, 1, 10'h005));
        idle_inputs();
        step("t3_after", mk(0, 0, 0, 0, 0, 0, 0, 10'h000));

        // 4: write miss 0x085 (no allocate), memory latency 1
        cpu_write = 1'b1; cpu_addr = 10'h085;
        step("t4_idle", mk(1, 1, 1, 0, 0, 0, 0, 10'h000));
        mem_ready = 1'b1;
        step("t4_w1",   mk(0, 1, 1, 0, 0, 0, 1, 10'h085));
        idle_inputs();
        cpu_read = 1'b1; cpu_addr = 10'h085;
        step("t4_p085", mk(1, 1, 1, 0, 0, 0, 0, 10'h000), 1'b1);
        cpu_read = 1'b1; cpu_addr = 10'h004;
        step("t4_h004", mk(0, 1, 0, 0, 0, 0, 0, 10'h000));
        idle_inputs();

        // 5: read 0x084 replaces the tag at index 1
        cpu_read = 1'b1; cpu_addr = 10'h084;
        step("t5_idle", mk(1, 1, 0, 0, 0, 0, 0, 10'h000));
        step("t5_rm1",  mk(1, 1, 0, 0, 0, 1, 0, 10'h084));
        mem_ready = 1'b1;
        step("t5_rm2",  mk(1, 1, 0, 0, 0, 1, 0, 10'h084));
        mem_ready = 1'b0;
        step("t5_fill", mk(1, 1, 0, 1, 0, 0, 0, 10'h000));
        step("t5_hit",  mk(0, 1, 0, 0, 0, 0, 0, 10'h000));
        idle_inputs();
        cpu_read = 1'b1; cpu_addr = 10'h004;
        step("t5_p004", mk(1, 1, 0, 0, 0, 0, 0, 10'h000), 1'b1);
        // read and write together: handled as the write only
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 10'h008;
        step("t5_rw_idle", mk(1, 2, 0, 0, 0, 0, 0, 10'h000));
        mem_ready = 1'b1;
        step("t5_rw_w1",   mk(0, 2, 0, 0, 0, 0, 1, 10'h008));
        idle_inputs();
        cpu_read = 1'b1; cpu_addr = 10'h008;
        step("t5_p008", mk(1, 2, 0, 0, 0, 0, 0, 10'h000), 1'b1);

        // 6: asynchronous reset in the middle of a read miss
        cpu_read = 1'b1; cpu_addr = 10'h004;
        step("t6_idle", mk(1, 1, 0, 0, 0, 0, 0, 10'h000));
        step("t6_rm1",  mk(1, 1, 0, 0, 0, 1, 0, 10'h004));
        reset = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        check_now("t6_rst_now");
        step("t6_rst_hold", mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        reset = 1'b1;
        idle_inputs();
        mem_ready = 1'b1;
        step("t6_stray", mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        mem_ready = 1'b0;
        step("t6_after", mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        cpu_read = 1'b1; cpu_addr = 10'h084;
        step("t6_p084", mk(1, 1, 0, 0, 0, 0, 0, 10'h000), 1'b1);
        cpu_read = 1'b1; cpu_addr = 10'h004;
        step("t6_idle2", mk(1, 1, 0, 0, 0, 0, 0, 10'h000));
        mem_ready = 1'b1;
        step("t6_rm",    mk(1, 1, 0, 0, 0, 1, 0, 10'h004));
        mem_ready = 1'b0;
        step("t6_fill",  mk(1, 1, 0, 1, 0, 0, 0, 10'h000));
        step("t6_hit",   mk(0, 1, 0, 0, 0, 0, 0, 10'h000));
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
